dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, data-memory word-address width.
REQ-002 Parameter MEM_RD_LAT, default 1, cycles from mem_rden sampled by memory to valid mem_q; legal 1..3.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Ports p_req/p_we  input  1 each  processor request / write-not-read.
REQ-006 Ports p_addr  input  ADDR_W; p_wdata  input  16  processor command.
REQ-007 Ports p_gnt, p_rvalid  output  1 each  processor accept / read-data valid.
REQ-008 Ports e_req, e_we, e_addr, e_wdata, e_gnt, e_rvalid  same widths and directions, external loader side.
REQ-009 Port e_lock  input  1  external requests exclusive memory ownership.
REQ-010 Ports mem_addr  output  ADDR_W; mem_wdata  output  16; mem_wren, mem_rden  output  1  memory command.
REQ-011 Port mem_q  input  16  memory read data.
REQ-012 Port rdata  output  16  shared read-return bus, qualified by p_rvalid/e_rvalid.
REQ-013 Port conflict_cnt  output  8  processor stall counter.

Function
REQ-014 FSM states ARB, DRAIN, LOCK; at most one command accepted per cycle.
REQ-015 x_gnt combinational; command accepted on the rising edge where x_req and x_gnt are both high; requester holds command stable until then.
REQ-016 Accepted command registered onto mem_* the following cycle; mem_wren/mem_rden high for exactly one cycle per command, both low when idle.
REQ-017 ARB: single requester granted same cycle; both requesting -> round-robin, winner is the requester not granted last.
REQ-018 ARB with e_lock high -> DRAIN; no grants in DRAIN.
REQ-019 DRAIN -> LOCK once no read is in flight (including the command registered that cycle).
REQ-020 LOCK: only E granted; p_gnt held low; e_lock low -> ARB next cycle.
REQ-021 e_lock dropped in DRAIN -> ARB directly.
REQ-022 Read return: x_rvalid pulses exactly MEM_RD_LAT+1 cycles after acceptance edge, only to the issuing requester; rdata = mem_q in that cycle, else held.
REQ-023 Back-to-back reads from mixed requesters return in issue order, one per cycle, tags tracked in a MEM_RD_LAT+1 deep shift register.
REQ-024 Writes produce no rvalid.
REQ-025 conflict_cnt increments every cycle p_req high and p_gnt low; saturates at 255; never wraps.

Reset
REQ-026 rst asserted: state ARB, last-winner = E (P wins first tie), read tag pipeline cleared, all outputs 0, conflict_cnt 0.
REQ-027 rst mid-operation: in-flight reads discarded, no rvalid issued after reset release for them.

Configuration
REQ-028 Macro DMEM_ARB_EXT_PRIO_EN defined: in ARB, E wins every tie (fixed priority); last-winner register unused.
REQ-029 DMEM_ARB_EXT_PRIO_EN undefined: round-robin per REQ-017; all other behaviour identical.

Verification
REQ-030 p_req read addr 0x005 alone, MEM_RD_LAT=1 -> p_gnt same cycle, mem_rden next cycle, p_rvalid 2 cycles after accept, rdata = mem[5].
REQ-031 p_req and e_req writes held 4 cycles after reset -> grants P,E,P,E alternating; with DMEM_ARB_EXT_PRIO_EN -> E,E,E,E, P gets none.
REQ-032 E read accepted, e_lock raised next cycle while p_req high -> no grants until e_rvalid, then LOCK; p_gnt low until e_lock drops.
REQ-033 p_req held with e_lock locked 300 cycles -> conflict_cnt reaches 255 and stays.
REQ-034 rst pulsed one cycle after P read accepted -> all outputs 0, p_rvalid never asserts for that read.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (processor P, external loader E) with round-robin ties and an exclusive E lock.
// Latency: grant is combinational, the command reaches mem_* one cycle after acceptance, and rvalid follows MEM_RD_LAT+1 cycles after acceptance.
// Backpressure: a requester holds its command until x_gnt is high. Macro DMEM_ARB_EXT_PRIO_EN gives E fixed priority on ties.
module dmem_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [15:0]       p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [15:0]       e_wdata,
    output logic              e_gnt,
    output logic              e_rvalid,
    input  logic              e_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_wren,
    output logic              mem_rden,
    input  logic [15:0]       mem_q,
    output logic [15:0]       rdata,
    output logic [7:0]        conflict_cnt
);

    localparam int TAG_D = MEM_RD_LAT + 1;

    typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_LOCK} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_p_gnt;
    logic              w_e_gnt;
    logic              w_tie_e;
    logic              w_p_acc;
    logic              w_e_acc;
    logic              w_acc;
    logic              w_acc_we;
    logic              w_rd_inflight;
    logic [TAG_D-1:0]  r_tag_vld;
    logic [TAG_D-1:0]  r_tag_e;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_mem_wren;
    logic              r_mem_rden;
    logic              r_p_rvalid;
    logic              r_e_rvalid;
    logic [15:0]       r_rdata;
    logic [7:0]        r_cnt;

`ifdef DMEM_ARB_EXT_PRIO_EN
    // E always wins a tie, so no history is needed.
    assign w_tie_e = 1'b1;
`else
    logic r_last_e;

    // Tie goes to whichever requester was not granted last.
    assign w_tie_e = ~r_last_e;

    // Remember the most recent winner; reset to E so P wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_e <= 1'b1;
        end else if (w_p_acc) begin
            r_last_e <= 1'b0;
        end else if (w_e_acc) begin
            r_last_e <= 1'b1;
        end
    end
`endif

    assign w_p_acc       = p_req & w_p_gnt;
    assign w_e_acc       = e_req & w_e_gnt;
    assign w_acc         = w_p_acc | w_e_acc;
    assign w_acc_we      = w_e_acc ? e_we : p_we;
    // The tag pipeline includes stage 0, which mirrors the command now on mem_*.
    assign w_rd_inflight = |r_tag_vld;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: lock waits for outstanding reads to drain before E owns memory.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:   if (e_lock) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!e_lock) begin
                    w_state_nxt = ST_ARB;
                end else if (!w_rd_inflight) begin
                    w_state_nxt = ST_LOCK;
                end
            end
            ST_LOCK:  if (!e_lock) w_state_nxt = ST_ARB;
            default:  w_state_nxt = ST_ARB;
        endcase
    end

    // FSM outputs: the grants. Nothing is granted during reset or once a lock request is seen in ARB.
    always_comb begin
        w_p_gnt = 1'b0;
        w_e_gnt = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_ARB: begin
                    if (!e_lock) begin
                        if (p_req && e_req) begin
                            w_e_gnt = w_tie_e;
                            w_p_gnt = ~w_tie_e;
                        end else begin
                            w_p_gnt = p_req;
                            w_e_gnt = e_req;
                        end
                    end
                end
                ST_LOCK: w_e_gnt = e_req;
                default: ;
            endcase
        end
    end

    // Register the accepted command onto the memory port; strobes last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
        end else begin
            r_mem_wren <= w_acc & w_acc_we;
            r_mem_rden <= w_acc & ~w_acc_we;
            if (w_acc) begin
                r_mem_addr  <= w_e_acc ? e_addr  : p_addr;
                r_mem_wdata <= w_e_acc ? e_wdata : p_wdata;
            end
        end
    end

    // Read tags shift one stage per cycle so return order matches issue order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_e   <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[TAG_D-2:0], w_acc & ~w_acc_we};
            r_tag_e   <= {r_tag_e[TAG_D-2:0], w_e_acc};
        end
    end

    // Return read data to the issuing side; rdata holds between returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_rvalid <= 1'b0;
            r_e_rvalid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_p_rvalid <= r_tag_vld[TAG_D-1] & ~r_tag_e[TAG_D-1];
            r_e_rvalid <= r_tag_vld[TAG_D-1] &  r_tag_e[TAG_D-1];
            if (r_tag_vld[TAG_D-1]) begin
                r_rdata <= mem_q;
            end
        end
    end

    // Count processor stall cycles, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (p_req && !w_p_gnt && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign p_gnt        = w_p_gnt;
    assign e_gnt        = w_e_gnt;
    assign p_rvalid     = r_p_rvalid;
    assign e_rvalid     = r_e_rvalid;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wren     = r_mem_wren;
    assign mem_rden     = r_mem_rden;
    assign rdata        = r_rdata;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, single read, tie arbitration, back-to-back reads, lock, saturation, mid-flight reset.
// Latency: the memory model returns data one cycle after it samples mem_rden (MEM_RD_LAT=1).
// Backpressure: the bench drives on the falling edge and holds each request until it is granted.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_req, p_we, e_req, e_we, e_lock;
    logic [8:0]  p_addr, e_addr, mem_addr;
    logic [15:0] p_wdata, e_wdata, mem_wdata, mem_q, rdata;
    logic        p_gnt, p_rvalid, e_gnt, e_rvalid, mem_wren, mem_rden;
    logic [7:0]  conflict_cnt;
    logic [15:0] r_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: word at address a holds 0xA000 | a; one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rden) r_q <= 16'hA000 | {7'h0, mem_addr};
    end
    assign mem_q = r_q;

    dmem_arbiter #(.ADDR_W(9), .MEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_lock(e_lock),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_q(mem_q), .rdata(rdata), .conflict_cnt(conflict_cnt)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        p_req = 1'b1; e_req = 1'b1; p_we = 1'b0; e_we = 1'b0; e_lock = 1'b0;
        p_addr = 9'h0; e_addr = 9'h0; p_wdata = 16'h0; e_wdata = 16'h0;
        rst = 1'b1;
        step(); step();
        #1;
        checks++;
        if ({p_gnt, e_gnt, p_rvalid, e_rvalid, mem_wren, mem_rden, mem_addr, mem_wdata, rdata, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b wr=%b rd=%b addr=%h wd=%h rdata=%h cnt=%0d, required all 0",
                     p_gnt, e_gnt, p_rvalid, e_rvalid, mem_wren, mem_rden, mem_addr, mem_wdata, rdata, conflict_cnt);
        end
        @(negedge clk);
        p_req = 1'b0; e_req = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h005;
        #1;
        checks++;
        if ({p_gnt, e_gnt} !== 2'b10) begin
            errors++; $display("FAIL single_gnt: got %b, required 10", {p_gnt, e_gnt});
        end
        step();
        p_req = 1'b0;
        checks++;
        if ({mem_rden, mem_wren, mem_addr} !== {1'b1, 1'b0, 9'h005}) begin
            errors++; $display("FAIL single_mem_cmd: rden=%b wren=%b addr=%h, required 1 0 005", mem_rden, mem_wren, mem_addr);
        end
        step();
        checks++;
        if ({mem_rden, p_rvalid} !== 2'b00) begin
            errors++; $display("FAIL single_idle: rden=%b p_rvalid=%b, required 0 0", mem_rden, p_rvalid);
        end
        step();
        checks++;
        if ({p_rvalid, e_rvalid, rdata} !== {2'b10, 16'hA005}) begin
            errors++; $display("FAIL single_return: rv=%b%b rdata=%h, required 10 A005", p_rvalid, e_rvalid, rdata);
        end
        step();
        checks++;
        if ({p_rvalid, rdata} !== {1'b0, 16'hA005}) begin
            errors++; $display("FAIL single_hold: p_rvalid=%b rdata=%h, required 0 A005", p_rvalid, rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        logic [7:0] exp_cnt;
`ifdef DMEM_ARB_EXT_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_cnt = 8'd4;
`else
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_cnt = 8'd2;
`endif
        pulse_reset();
        p_req = 1'b1; p_we = 1'b1; p_addr = 9'h010; p_wdata = 16'h1111;
        e_req = 1'b1; e_we = 1'b1; e_addr = 9'h020; e_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({p_gnt, e_gnt} !== exp_g[i]) begin
                errors++; $display("FAIL rr_gnt%0d: got %b, required %b", i, {p_gnt, e_gnt}, exp_g[i]);
            end
            step();
            checks++;
            if ({mem_wren, mem_rden, mem_addr, mem_wdata} !==
                {2'b10, (exp_g[i][1] ? 9'h010 : 9'h020), (exp_g[i][1] ? 16'h1111 : 16'h2222)}) begin
                errors++; $display("FAIL rr_write%0d: wren=%b rden=%b addr=%h wd=%h", i, mem_wren, mem_rden, mem_addr, mem_wdata);
            end
        end
        p_req = 1'b0; e_req = 1'b0;
        checks++;
        if (conflict_cnt !== exp_cnt) begin
            errors++; $display("FAIL rr_conflict_cnt: got %0d, required %0d", conflict_cnt, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({p_rvalid, e_rvalid} !== 2'b00) begin
                errors++; $display("FAIL write_no_rvalid%0d: got %b, required 00", i, {p_rvalid, e_rvalid});
            end
        end
    endtask

    task automatic test_back_to_back();
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h003;
        step();
        p_req = 1'b0;
        e_req = 1'b1; e_we = 1'b0; e_addr = 9'h007;
        #1;
        checks++;
        if ({p_gnt, e_gnt} !== 2'b01) begin
            errors++; $display("FAIL b2b_e_gnt: got %b, required 01", {p_gnt, e_gnt});
        end
        step();
        e_req = 1'b0;
        p_req = 1'b1; p_addr = 9'h009;
        step();
        p_req = 1'b0;
        checks++;
        if ({p_rvalid, e_rvalid, rdata} !== {2'b10, 16'hA003}) begin
            errors++; $display("FAIL b2b_ret0: rv=%b%b rdata=%h, required 10 A003", p_rvalid, e_rvalid, rdata);
        end
        step();
        checks++;
        if ({p_rvalid, e_rvalid, rdata} !== {2'b01, 16'hA007}) begin
            errors++; $display("FAIL b2b_ret1: rv=%b%b rdata=%h, required 01 A007", p_rvalid, e_rvalid, rdata);
        end
        step();
        checks++;
        if ({p_rvalid, e_rvalid, rdata} !== {2'b10, 16'hA009}) begin
            errors++; $display("FAIL b2b_ret2: rv=%b%b rdata=%h, required 10 A009", p_rvalid, e_rvalid, rdata);
        end
        step();
        checks++;
        if ({p_rvalid, e_rvalid} !== 2'b00) begin
            errors++; $display("FAIL b2b_after: rv=%b%b, required 00", p_rvalid, e_rvalid);
        end
    endtask

    task automatic test_lock();
        pulse_reset();
        e_req = 1'b1; e_we = 1'b0; e_addr = 9'h00C;
        #1;
        checks++;
        if (e_gnt !== 1'b1) begin
            errors++; $display("FAIL lock_e_read_gnt: got %b, required 1", e_gnt);
        end
        step();
        e_req = 1'b0; e_lock = 1'b1;
        p_req = 1'b1; p_we = 1'b1; p_addr = 9'h030; p_wdata = 16'h3333;
        #1;
        checks++;
        if ({p_gnt, e_gnt} !== 2'b00) begin
            errors++; $display("FAIL lock_arb_nogrant: got %b, required 00", {p_gnt, e_gnt});
        end
        step();
        checks++;
        if ({p_gnt, e_rvalid} !== 2'b00) begin
            errors++; $display("FAIL lock_drain: p_gnt=%b e_rvalid=%b, required 0 0", p_gnt, e_rvalid);
        end
        step();
        checks++;
        if ({e_rvalid, p_rvalid, p_gnt, rdata} !== {3'b100, 16'hA00C}) begin
            errors++; $display("FAIL lock_e_return: erv=%b prv=%b p_gnt=%b rdata=%h, required 1 0 0 A00C", e_rvalid, p_rvalid, p_gnt, rdata);
        end
        step();
        e_req = 1'b1; e_we = 1'b1; e_addr = 9'h031; e_wdata = 16'h4444;
        #1;
        checks++;
        if ({p_gnt, e_gnt} !== 2'b01) begin
            errors++; $display("FAIL lock_only_e: got %b, required 01", {p_gnt, e_gnt});
        end
        step();
        e_req = 1'b0;
        checks++;
        if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 9'h031, 16'h4444}) begin
            errors++; $display("FAIL lock_e_write: wren=%b addr=%h wd=%h, required 1 031 4444", mem_wren, mem_addr, mem_wdata);
        end
        e_lock = 1'b0;
        #1;
        checks++;
        if (p_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_release_cycle: p_gnt=%b, required 0", p_gnt);
        end
        step();
        #1;
        checks++;
        if (p_gnt !== 1'b1) begin
            errors++; $display("FAIL lock_back_to_arb: p_gnt=%b, required 1", p_gnt);
        end
        step();
        p_req = 1'b0;
        checks++;
        if (conflict_cnt !== 8'd5) begin
            errors++; $display("FAIL lock_conflict_cnt: got %0d, required 5", conflict_cnt);
        end
    endtask

    task automatic test_saturate();
        logic saw_gnt;
        saw_gnt = 1'b0;
        e_lock = 1'b1; p_req = 1'b1; p_we = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (p_gnt) saw_gnt = 1'b1;
            step();
        end
        checks++;
        if (saw_gnt !== 1'b0) begin
            errors++; $display("FAIL sat_p_gnt: p_gnt seen high while locked, required never");
        end
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_reach: got %0d, required 255", conflict_cnt);
        end
        step(); step(); step();
        checks++;
        if (conflict_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_hold: got %0d, required 255", conflict_cnt);
        end
        e_lock = 1'b0; p_req = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_midflight();
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h00A;
        step();
        p_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({p_gnt, e_gnt, p_rvalid, e_rvalid, mem_wren, mem_rden, mem_addr, mem_wdata, rdata, conflict_cnt} !== '0) begin
            errors++; $display("FAIL midrst_outputs: rd=%b addr=%h rdata=%h cnt=%0d, required all 0", mem_rden, mem_addr, rdata, conflict_cnt);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({p_rvalid, e_rvalid} !== 2'b00) begin
                errors++; $display("FAIL midrst_no_rvalid%0d: got %b, required 00", i, {p_rvalid, e_rvalid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_lock();
        test_saturate();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
